// File: rtl/trace_pkg.sv
// Shared constants for the trace capture controller: FSM state encoding and parameter defaults.
// Imported by the controller and sized against by integrators.
package trace_pkg;

   localparam int TRACE_W_DEF     = 1;
   localparam int TRACE_DEPTH_DEF = 8;
   localparam int TRACE_TS_W_DEF  = 16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on rd_dat_o whenever not empty, pop takes effect next edge.
// clr_i empties the FIFO and may be combined with a write on the same edge, which lands in slot 0.
module trace_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clr_i,
   input  logic                    wr_en_i,
   input  logic [WIDTH-1:0]        wr_dat_i,
   input  logic                    rd_en_i,
   output logic [WIDTH-1:0]        rd_dat_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_base;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_wr, do_rd;

   // A clear discards current contents, so a write alongside it is never blocked by full.
   always_comb begin
      wr_base  = clr_i ? '0 : wr_ptr_q;
      do_wr    = wr_en_i && (clr_i || !full_o);
      do_rd    = rd_en_i && !clr_i && !empty_o;
      wr_ptr_d = wr_base + AW'(do_wr);
      rd_ptr_d = clr_i ? '0 : rd_ptr_q + AW'(do_rd);
      cnt_d    = (clr_i ? '0 : cnt_q) + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wr_base] <= wr_dat_i;
      end
   end

   assign rd_dat_o = mem_q[rd_ptr_q];
   assign full_o   = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o  = (cnt_q == '0);
   assign count_o  = cnt_q;

endmodule

// File: rtl/trace_capture_ctrl.sv
// Change-only trace recorder: on arm, logs d with a cycle timestamp whenever it changes, then drains
// the log through a valid/ready port. Storage lives in trace_fifo; FSM and timestamp counter live here.
module trace_capture_ctrl
   import trace_pkg::*;
#(
   parameter int W     = TRACE_W_DEF,
   parameter int DEPTH = TRACE_DEPTH_DEF,
   parameter int TS_W  = TRACE_TS_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    arm,
   input  logic                    stop,
   input  logic [W-1:0]            d,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [W-1:0]            rd_data,
   output logic [TS_W-1:0]         rd_time,
   output logic [1:0]              state,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow
);

   localparam int               EW     = W + TS_W;
   localparam logic [TS_W-1:0]  TS_MAX = '1;

   logic [1:0]       state_q, state_d;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic [W-1:0]     prev_q, prev_d;
   logic             ovf_q, ovf_d;

   logic             fifo_clr, fifo_wr, fifo_rd;
   logic             fifo_full, fifo_empty;
   logic [EW-1:0]    fifo_wr_dat, fifo_rd_dat;
   logic [$clog2(DEPTH):0] fifo_count;
   logic             changed;

   always_comb begin
      state_d     = state_q;
      ts_d        = ts_q;
      prev_d      = prev_q;
      ovf_d       = ovf_q;
      fifo_clr    = 1'b0;
      fifo_wr     = 1'b0;
      fifo_wr_dat = {d, ts_q};
      changed     = (d != prev_q);

      case (state_q)
         ST_IDLE: begin
            if (arm) begin
               fifo_clr    = 1'b1;
               fifo_wr     = 1'b1;
               fifo_wr_dat = {d, {TS_W{1'b0}}};
               ovf_d       = 1'b0;
               prev_d      = d;
               ts_d        = TS_W'(1);
               state_d     = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            prev_d = d;
            if (ts_q != TS_MAX) begin
               ts_d = ts_q + TS_W'(1);
            end
            // A change that finds the buffer full is lost; the capture window ends there.
            if (changed) begin
               if (fifo_full) begin
                  ovf_d   = 1'b1;
                  state_d = ST_DRAIN;
               end else begin
                  fifo_wr = 1'b1;
               end
            end
            if (stop || (ts_q == TS_MAX)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ts_q    <= '0;
         prev_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ts_q    <= ts_d;
         prev_q  <= prev_d;
         ovf_q   <= ovf_d;
      end
   end

   trace_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk),
      .rst_i    (rst),
      .clr_i    (fifo_clr),
      .wr_en_i  (fifo_wr),
      .wr_dat_i (fifo_wr_dat),
      .rd_en_i  (fifo_rd),
      .rd_dat_o (fifo_rd_dat),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .count_o  (fifo_count)
   );

   // Head is only presented while draining, so the port reads zero otherwise (including under reset).
   assign rd_valid = (state_q == ST_DRAIN) && !fifo_empty;
   assign fifo_rd  = rd_valid && rd_ready;
   assign rd_data  = rd_valid ? fifo_rd_dat[EW-1:TS_W] : '0;
   assign rd_time  = rd_valid ? fifo_rd_dat[TS_W-1:0] : '0;
   assign state    = state_q;
   assign count    = fifo_count;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: queue-based reference model checked every cycle plus directed scenarios.
module tb_trace_capture_ctrl;

   localparam int W      = 2;
   localparam int DEPTH  = 4;
   localparam int TS_W   = 4;
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam int EW     = W + TS_W;
   localparam int TS_MAX = (1 << TS_W) - 1;
   localparam int S_IDLE = 0;
   localparam int S_CAP  = 1;
   localparam int S_DRN  = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            arm = 1'b0;
   logic            stop = 1'b0;
   logic            rd_ready = 1'b0;
   logic [W-1:0]    d = '0;
   logic            rd_valid;
   logic [W-1:0]    rd_data;
   logic [TS_W-1:0] rd_time;
   logic [1:0]      state;
   logic [CW-1:0]   count;
   logic            overflow;

   always #5 clk = ~clk;

   trace_capture_ctrl #(
      .W     (W),
      .DEPTH (DEPTH),
      .TS_W  (TS_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .stop     (stop),
      .d        (d),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_time  (rd_time),
      .state    (state),
      .count    (count),
      .overflow (overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] ent(input int dv, input int t);
      return {W'(dv), TS_W'(t)};
   endfunction

   // Reference model: a list of recorded (value, time) pairs and the capture rules.
   int             m_state = S_IDLE;
   logic [EW-1:0]  m_q[$];
   int             m_ts = 0;
   logic [W-1:0]   m_prev = '0;
   bit             m_ovf = 1'b0;
   bit             m_leave;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state = S_IDLE;
         m_q.delete();
         m_ts   = 0;
         m_prev = '0;
         m_ovf  = 1'b0;
      end else begin
         case (m_state)
            S_IDLE: if (arm) begin
               m_q.delete();
               m_q.push_back(ent(int'(d), 0));
               m_ovf   = 1'b0;
               m_prev  = d;
               m_ts    = 1;
               m_state = S_CAP;
            end
            S_CAP: begin
               m_leave = stop || (m_ts == TS_MAX);
               if (d !== m_prev) begin
                  if (m_q.size() == DEPTH) begin
                     m_ovf   = 1'b1;
                     m_leave = 1'b1;
                  end else begin
                     m_q.push_back(ent(int'(d), m_ts));
                  end
               end
               m_prev = d;
               if (m_ts < TS_MAX) m_ts++;
               if (m_leave) m_state = S_DRN;
            end
            default: begin
               if (m_q.size() == 0) m_state = S_IDLE;
               else if (rd_ready) void'(m_q.pop_front());
            end
         endcase
      end
   end

   always @(negedge clk) begin : cmp
      bit ev;
      ev = (m_state == S_DRN) && (m_q.size() != 0);
      chk("model state", 32'(state), 32'(m_state));
      chk("model count", 32'(count), 32'(m_q.size()));
      chk("model rd_valid", 32'(rd_valid), 32'(ev));
      chk("model overflow", 32'(overflow), 32'(m_ovf));
      if (ev) chk("model head", 32'({rd_data, rd_time}), 32'(m_q[0]));
   end

   logic [EW-1:0] pops[$];
   logic [EW-1:0] exp_q[$];

   always @(posedge clk) begin
      if (!rst && rd_valid && rd_ready) pops.push_back({rd_data, rd_time});
   end

   task automatic step(input bit a, input bit s, input int dv, input bit r);
      arm      = a;
      stop     = s;
      d        = W'(dv);
      rd_ready = r;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic drain_check(input string name);
      int n;
      pops.delete();
      n = 0;
      while (state != 2'd0 && n < 20) begin
         step(0, 0, int'(d), 1);
         n++;
      end
      chk({name, " reaches idle"}, 32'(state == 2'd0), 32'd1);
      chk({name, " pop count"}, 32'(pops.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < pops.size()) chk($sformatf("%s pop%0d", name, i), 32'(pops[i]), 32'(exp_q[i]));
      end
   endtask

   int seq_a[8] = '{0, 0, 1, 0, 0, 1, 1, 1};
   int n_sat;

   initial begin
      @(negedge clk);
      #1;
      chk("reset state", 32'(state), 32'd0);
      chk("reset count", 32'(count), 32'd0);
      chk("reset rd_valid", 32'(rd_valid), 32'd0);
      chk("reset overflow", 32'(overflow), 32'd0);
      chk("reset rd_data", 32'(rd_data), 32'd0);
      chk("reset rd_time", 32'(rd_time), 32'd0);
      rst = 1'b0;
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("stop in idle ignored", 32'(state), 32'd0);

      // Basic capture: changes at edges 3, 4, 6; stop at edge 8.
      step(1, 0, 0, 0);
      chk("basic armed state", 32'(state), 32'd1);
      chk("basic armed count", 32'(count), 32'd1);
      for (int i = 1; i <= 8; i++) step(0, i == 8, seq_a[i-1], i == 8);
      chk("basic drain state", 32'(state), 32'd2);
      chk("basic drain count", 32'(count), 32'd4);
      exp_q.delete();
      exp_q.push_back(ent(0, 0));
      exp_q.push_back(ent(1, 3));
      exp_q.push_back(ent(0, 4));
      exp_q.push_back(ent(1, 6));
      drain_check("basic");
      chk("basic overflow", 32'(overflow), 32'd0);

      // Overflow: toggle every edge into a 4-deep buffer.
      step(1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) step(0, 0, i % 2, 0);
      chk("ovf state", 32'(state), 32'd2);
      chk("ovf count", 32'(count), 32'd4);
      chk("ovf flag", 32'(overflow), 32'd1);
      exp_q.delete();
      exp_q.push_back(ent(0, 0));
      exp_q.push_back(ent(1, 1));
      exp_q.push_back(ent(0, 2));
      exp_q.push_back(ent(1, 3));
      drain_check("ovf");
      chk("ovf sticky in idle", 32'(overflow), 32'd1);

      // Backpressure with three entries; arm during drain must be ignored.
      step(1, 0, 2, 0);
      chk("arm clears overflow", 32'(overflow), 32'd0);
      step(0, 0, 3, 0);
      step(0, 1, 1, 0);
      chk("bp count", 32'(count), 32'd3);
      for (int i = 0; i < 5; i++) begin
         step(i == 2, 0, 1, 0);
         chk("bp rd_valid", 32'(rd_valid), 32'd1);
         chk("bp head stable", 32'({rd_data, rd_time}), 32'(ent(2, 0)));
         chk("bp count held", 32'(count), 32'd3);
      end
      chk("arm in drain ignored", 32'(state), 32'd2);
      pops.delete();
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
      chk("bp pops in 3 cycles", 32'(pops.size()), 32'd3);
      if (pops.size() == 3) begin
         chk("bp pop0", 32'(pops[0]), 32'(ent(2, 0)));
         chk("bp pop1", 32'(pops[1]), 32'(ent(3, 1)));
         chk("bp pop2", 32'(pops[2]), 32'(ent(1, 2)));
      end
      chk("bp empty", 32'(count), 32'd0);
      step(0, 0, 1, 0);
      chk("bp back to idle", 32'(state), 32'd0);

      // Arm and stop together in IDLE; stop plus change at edge 5.
      step(1, 1, 0, 0);
      chk("arm wins over stop", 32'(state), 32'd1);
      for (int i = 1; i <= 4; i++) step(0, 0, 0, 0);
      step(0, 1, 3, 0);
      chk("simul state", 32'(state), 32'd2);
      chk("simul count", 32'(count), 32'd2);
      exp_q.delete();
      exp_q.push_back(ent(0, 0));
      exp_q.push_back(ent(3, 5));
      drain_check("simul");

      // Reset mid-capture takes effect before the next edge.
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      chk("pre-reset count", 32'(count), 32'd2);
      #1 rst = 1'b1;
      #1;
      chk("async rst state", 32'(state), 32'd0);
      chk("async rst count", 32'(count), 32'd0);
      chk("async rst rd_valid", 32'(rd_valid), 32'd0);
      chk("async rst overflow", 32'(overflow), 32'd0);
      chk("async rst rd_data", 32'(rd_data), 32'd0);
      chk("async rst rd_time", 32'(rd_time), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      step(1, 0, 1, 0);
      chk("arm after reset state", 32'(state), 32'd1);
      chk("arm after reset count", 32'(count), 32'd1);
      step(0, 1, 1, 0);
      exp_q.delete();
      exp_q.push_back(ent(1, 0));
      drain_check("post-reset");

      // Timestamp saturation with a constant input.
      step(1, 0, 1, 0);
      n_sat = 0;
      do begin
         step(0, 0, 1, 0);
         n_sat++;
      end while (state == 2'd1 && n_sat < 40);
      chk("sat capture edges", 32'(n_sat), 32'd15);
      chk("sat state", 32'(state), 32'd2);
      chk("sat count", 32'(count), 32'd1);
      exp_q.delete();
      exp_q.push_back(ent(1, 0));
      drain_check("sat");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 Parameter W, default 1, width of watched signal d.
REQ-002 Parameter DEPTH, default 8, trace buffer entries (power of two, >=2).
REQ-003 Parameter TS_W, default 16, timestamp width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 arm  in  1  start capture (honoured in IDLE only).
REQ-007 stop  in  1  end capture (honoured in CAPTURE only).
REQ-008 d  in  W  watched signal, sampled each rising edge.
REQ-009 rd_valid  out  1  trace entry available.
REQ-010 rd_ready  in  1  consumer accepts entry.
REQ-011 rd_data  out  W  recorded value of head entry.
REQ-012 rd_time  out  TS_W  cycle timestamp of head entry.
REQ-013 state  out  2  IDLE=0, CAPTURE=1, DRAIN=2.
REQ-014 count  out  $clog2(DEPTH)+1  entries held.
REQ-015 overflow  out  1  sticky: a change was dropped.

Function
REQ-016 States SHALL be IDLE, CAPTURE, DRAIN; encoding 3 unused, SHALL go to IDLE.
REQ-017 IDLE & arm: SHALL clear buffer, overflow, write entry {d, 0}, set prev=d, ts=1, go CAPTURE.
REQ-018 CAPTURE, each edge: if d != prev, SHALL write {d, ts}; prev=d; ts=ts+1, saturating at 2^TS_W-1.
REQ-019 CAPTURE: change while count==DEPTH SHALL drop entry, set overflow, go DRAIN.
REQ-020 CAPTURE & stop SHALL go DRAIN; a change on the same edge SHALL still be recorded (subject to REQ-019).
REQ-021 CAPTURE with ts at saturation SHALL go DRAIN on that edge, after recording any change.
REQ-022 rd_valid SHALL equal (state==DRAIN && count!=0); no reads in IDLE/CAPTURE.
REQ-023 rd_valid & rd_ready SHALL pop head; next entry visible following cycle (zero-latency show-ahead).
REQ-024 rd_data/rd_time SHALL hold stable while rd_valid & !rd_ready.
REQ-025 DRAIN with count==0 SHALL go IDLE next edge; overflow SHALL persist until next arm.
REQ-026 arm outside IDLE and stop outside CAPTURE SHALL be ignored; arm & stop together in IDLE: arm wins.
REQ-027 Entries SHALL pop in write (timestamp) order; timestamps strictly increasing.

Reset
REQ-028 rst SHALL immediately force state=IDLE, count=0, rd_valid=0, overflow=0, rd_data=0, rd_time=0, ts=0, prev=0.
REQ-029 rst mid-CAPTURE or mid-DRAIN SHALL discard all entries; arm on first edge after release SHALL be honoured.

Structure
REQ-030 Package trace_pkg SHALL hold state encoding constants and parameter defaults.
REQ-031 Storage SHALL be sub-module trace_fifo (sync FIFO, show-ahead, width W+TS_W, depth DEPTH, full/empty/count); FSM and timestamp in top.

Verification
REQ-032 Basic: d=0 at arm edge 0; d sampled 1 at edge 3, 0 at 4, 1 at 6; stop at edge 8, rd_ready=1 -> pops (0,0),(1,3),(0,4),(1,6), then IDLE, overflow=0.
REQ-033 Overflow: DEPTH=4, d toggles every cycle after arm -> 4 entries (t=0,1,2,3), change at t=4 dropped, overflow=1, DRAIN, count=4.
REQ-034 Backpressure: in DRAIN with 3 entries, rd_ready low 5 cycles -> rd_valid=1, head stable, count=3; then ready high -> 3 pops on consecutive cycles.
REQ-035 Reset mid-capture: rst after 2 entries -> state=IDLE, count=0, rd_valid=0 immediately (before next edge).
REQ-036 Saturation: TS_W=4, d constant after arm -> DRAIN at edge with ts=15, single entry (d,0).
REQ-037 Simultaneous: stop and d change on edge 5 -> entry (new d,5) recorded, then DRAIN.
